// File: rtl/coh_bus_pkg.sv
// coh_bus_pkg: shared types and constants for the four-core bus controller
// Holds the FSM state encoding, requester count, default data width and a
// one-hot to index helper.
package coh_bus_pkg;
    localparam int N_REQ      = 4;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    function automatic logic [1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < N_REQ; k++)
            if (oh[k]) idx = 2'(k);
        return idx;
    endfunction
endpackage

// File: rtl/coh_bus_ctrl_rr_pick4.sv
// rr_pick4: combinational round-robin pick of the first requester at or after prio
// Ports: req  - 4-bit request vector
//        prio - 2-bit scan start pointer, wraps 3->0
//        pick - one-hot selected requester
//        vld  - at least one request present
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] prio,
    output logic [3:0] pick,
    output logic       vld
);
    logic [3:0] rot, first;
    always_comb begin
        rot   = prio == 2'd0 ? req :
                prio == 2'd1 ? {req[0], req[3:1]} :
                prio == 2'd2 ? {req[1:0], req[3:2]} : {req[2:0], req[3]};
        first = rot & (~rot + 4'd1);
        pick  = prio == 2'd0 ? first :
                prio == 2'd1 ? {first[2:0], first[3]} :
                prio == 2'd2 ? {first[1:0], first[3:2]} : {first[0], first[3:1]};
        vld   = |req;
    end
endmodule

// File: rtl/coh_bus_ctrl.sv
// coh_bus_ctrl: round-robin four-core shared-memory bus controller
// Ports: clk, rst (async active-high)
//        rd/wr/wdata        - per-core requests and packed write data
//        rdy/rdata/rdata_vld - per-core completion, read data and its qualifier
//        rd_m/wr_m/wdata_m/rdy_m/rdata_m - single memory port
//        gnt                - registered one-hot grant
//        inv                - write-invalidate snoop pulse
// Build option: COH_SNOOP_INV_EN enables the snoop invalidate broadcast;
// otherwise inv is tied to zero.
module coh_bus_ctrl
    import coh_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        rd,
    input  logic [N_REQ-1:0]        wr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        rdy,
    output logic [N_REQ*DATA_W-1:0] rdata,
    output logic [N_REQ-1:0]        rdata_vld,
    output logic                    rd_m,
    output logic                    wr_m,
    output logic [DATA_W-1:0]       wdata_m,
    input  logic                    rdy_m,
    input  logic [DATA_W-1:0]       rdata_m,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        inv
);
    state_t state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt, pick;
    logic [1:0] prio, prio_nxt;
    logic pick_vld;
    rr_pick4 u_pick (
        .req (rd | wr),
        .prio(prio),
        .pick(pick),
        .vld (pick_vld)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            prio      <= 2'd0;
            rdata_vld <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            prio      <= prio_nxt;
            rdata_vld <= rdy;
        end
    end
    // An abort (granted core drops its request) still advances prio so the
    // aborting core does not keep first place.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        prio_nxt  = prio;
        case (state)
            IDLE: if (pick_vld) begin
                state_nxt = BUSY;
                gnt_nxt   = pick;
            end
            BUSY: if (rdy_m || !(|((rd | wr) & gnt))) begin
                state_nxt = rdy_m ? DONE : IDLE;
                gnt_nxt   = '0;
                prio_nxt  = oh2idx(gnt) + 2'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        rdy     = state == BUSY ? {N_REQ{rdy_m}} & gnt : '0;
        rd_m    = |(rd & ~wr & gnt);
        wr_m    = |(wr & gnt);
        wdata_m = '0;
        rdata   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            wdata_m = wdata_m | (gnt[k] ? wdata[k*DATA_W +: DATA_W] : '0);
            rdata[k*DATA_W +: DATA_W] = rdata_vld[k] ? rdata_m : '0;
        end
    end
`ifdef COH_SNOOP_INV_EN
    logic wr_flag;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_flag <= 1'b0;
        else if (state == BUSY && rdy_m)
            wr_flag <= |(wr & gnt);
    end
    // In DONE, rdata_vld is exactly the completed core, so its complement
    // addresses every other core.
    assign inv = (state == DONE && wr_flag) ? ~rdata_vld : '0;
`else
    assign inv = '0;
`endif
endmodule

// File: doc/coh_bus_ctrl.md
Name: coh_bus_ctrl

Overview:
Shared-memory bus controller for the four-core coherency examples. It arbitrates core read/write requests round-robin and sequences one memory transaction at a time. It steers the winning core's command and data to the single mem port and returns rdy/rdata to the granted core only. It can optionally broadcast write-invalidate snoops to the non-granted cores, which is the first step toward the coherent variant.

Parameters:
DATA_W  8  width of wdata/rdata
N_REQ   4  number of requesters; fixed at 4, and other values are unsupported

Ports:
clk        in   1             system clock, posedge
rst        in   1             asynchronous, active-high reset
rd         in   4             per-core read request, bit i = core i
wr         in   4             per-core write request
wdata      in   4*DATA_W      packed core write data, core i at [i*DATA_W +: DATA_W]
rdy        out  4             per-core completion, combinational
rdata      out  4*DATA_W      packed read data per core, zero when not valid
rdata_vld  out  4             registered, one cycle after rdy, qualifies rdata
rd_m       out  1             memory read strobe
wr_m       out  1             memory write strobe
wdata_m    out  DATA_W        memory write data
rdy_m      in   1             memory completion, combinational
rdata_m    in   DATA_W        memory read data, valid the cycle after rdy_m
gnt        out  4             one-hot registered grant, all zero when idle
inv        out  4             snoop invalidate pulse, 1 cycle (feature-dependent)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, prio pointer=0, rdata_vld=0, inv=0.
  - All combinational outputs resolve to 0.
  - Reset mid-transaction abandons it with no rdy.
- Request:
  - Core i requests when rd[i]|wr[i].
  - Cores hold rd/wr/wdata stable until their rdy pulse.
  - wr has precedence: if rd[i]&wr[i], the memory sees wr_m=1, rd_m=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any request is present, pick the first requester at or after the prio pointer, wrapping 3->0.
  - Register it into gnt and go to BUSY. Grant is visible the cycle after the request is first sampled.
  - No request: stay in IDLE.
- BUSY:
  - rd_m/wr_m/wdata_m = live rd/wr/wdata of the granted core. They are gated by gnt, so they are 0 when gnt=0.
  - rdy[i] = rdy_m & gnt[i]; other rdy bits are 0.
  - On rdy_m: go to DONE, set prio = granted+1 mod 4, and latch whether the transaction was a write.
  - Abort: if the granted core drops both rd and wr before rdy_m, return to IDLE next cycle with no rdy. prio is still advanced.
  - No timeout; BUSY may last indefinitely.
- DONE (1 cycle):
  - gnt cleared, memory strobes 0.
  - rdata_vld[k]=1 for the completed core k.
  - rdata slice k = rdata_m; all other slices are 0.
  - Next state is IDLE.
  - Minimum spacing is 3 cycles per transaction (IDLE, BUSY, DONE) when rdy_m returns in the first BUSY cycle.
- Fairness: a continuously requesting core waits at most 3 other transactions.
- New requests arriving during BUSY/DONE are not sampled until IDLE.
- rdata_vld is registered from rdy; rdata is combinational from rdata_m gated by rdata_vld.

Optional Feature:
COH_SNOOP_INV_EN.
- Defined: in DONE after a completed write by core k, inv = all ones except bit k, for exactly one cycle. Reads and aborts produce no inv.
- Undefined: inv is tied to 4'b0, the write flag is not implemented, and behaviour is otherwise identical.

Decomposition:
- Package coh_bus_pkg holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - N_REQ;
  - the default DATA_W.
- One sub-module is natural: rr_pick4, combinational. Inputs are the 4-bit request vector and the 2-bit prio pointer; outputs are a one-hot pick and a valid flag.
- The muxing and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-BUSY (core 2 writing).
  - Expect gnt=0, rdy=0, rd_m=wr_m=0 immediately.
  - After release, a request from core 1 is granted first (prio=0 scan: 0,1,...).
- Single read: core 0 rd=1, mem rdy_m=1 first BUSY cycle, rdata_m=8'hA5 next cycle.
  - Expect gnt=4'b0001 one cycle after the request, then rdy=4'b0001.
  - Next cycle rdata_vld=4'b0001 and rdata[7:0]=8'hA5; other slices are 0.
- Round-robin: all four cores request continuously, each completing.
  - Expect grant order 0,1,2,3,0.
  - A new grant every 3 cycles with zero-latency memory.
- Write precedence and steering: core 3 rd=1, wr=1, wdata=8'h3C.
  - Expect wr_m=1, rd_m=0, wdata_m=8'h3C while gnt=4'b1000.
- Abort: core 1 granted, drops rd before rdy_m.
  - Expect return to IDLE with no rdy[1] and no rdata_vld.
  - prio advances to 2, so a simultaneous request from 0 and 2 grants core 2.
- Snoop (COH_SNOOP_INV_EN defined): core 2 completes a write.
  - Expect inv=4'b1011 for one cycle in DONE.
  - A completed read produces inv=0.
  - With the macro undefined, inv stays 0 throughout.
